// File: rtl/llr_frame_packer.sv
// Packs SAMPLES soft samples into one frame word and hands each frame to the turbo decoder with a start pulse.
// Ping-pong buffering lets the next frame fill while the decoder runs. Optional macro LLR_SAT_EN clips -2^(W-1) to -(2^(W-1)-1).
module llr_frame_packer #(
   parameter int SAMPLE_W = 7,
   parameter int SAMPLES  = 12,
   parameter int CNT_W    = 16
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_valid,
   output logic                         o_ready,
   input  logic [SAMPLE_W-1:0]          i_sample,
   output logic                         o_start,
   output logic [SAMPLE_W*SAMPLES-1:0]  o_data,
   input  logic                         i_done,
   output logic [CNT_W-1:0]             o_frame_cnt,
   output logic                         o_busy
);
   localparam int DATA_W = SAMPLE_W * SAMPLES;
   localparam int IDX_W  = $clog2(SAMPLES);

   typedef enum logic [1:0] {IDLE, START, BUSY} state_t;

   state_t              state_q;
   logic [1:0]          full_q, full_d;
   logic                wr_ptr_q, rd_ptr_q;
   logic [IDX_W-1:0]    idx_q;
   logic [DATA_W-1:0]   data_q;
   logic                start_q, busy_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [SAMPLE_W-1:0] sample_d;
   logic [DATA_W-1:0]   rd_buf;
   logic                accept, last_sample, release_buf;

`ifdef LLR_SAT_EN
   localparam logic [SAMPLE_W-1:0] MOST_NEG = {1'b1, {(SAMPLE_W-1){1'b0}}};
   localparam logic [SAMPLE_W-1:0] SAT_NEG  = {1'b1, {(SAMPLE_W-2){1'b0}}, 1'b1};
   // Symmetric range so the decoder can negate any LLR without overflow.
   assign sample_d = (i_sample == MOST_NEG) ? SAT_NEG : i_sample;
`else
   assign sample_d = i_sample;
`endif

   assign o_ready     = ~full_q[wr_ptr_q];
   assign accept      = i_valid & o_ready;
   assign last_sample = (idx_q == IDX_W'(SAMPLES - 1));
   assign release_buf = (state_q == BUSY) & i_done;

   for (genvar gi = 0; gi < 2; gi++) begin : g_buf
      logic [DATA_W-1:0] buf_q;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            buf_q <= '0;
         end else if (accept && (wr_ptr_q == 1'(gi))) begin
            buf_q[idx_q*SAMPLE_W +: SAMPLE_W] <= sample_d;
         end
      end
   end

   assign rd_buf = rd_ptr_q ? g_buf[1].buf_q : g_buf[0].buf_q;

   // Release and fill always target different buffers, so both updates apply.
   always_comb begin
      full_d = full_q;
      if (release_buf)
         full_d[rd_ptr_q] = 1'b0;
      if (accept && last_sample)
         full_d[wr_ptr_q] = 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         full_q   <= '0;
         wr_ptr_q <= 1'b0;
         idx_q    <= '0;
      end else begin
         full_q <= full_d;
         if (accept) begin
            if (last_sample) begin
               wr_ptr_q <= ~wr_ptr_q;
               idx_q    <= '0;
            end else begin
               idx_q <= idx_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         rd_ptr_q <= 1'b0;
         data_q   <= '0;
         start_q  <= 1'b0;
         busy_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         start_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (full_q[rd_ptr_q]) begin
                  state_q <= START;
                  data_q  <= rd_buf;
                  start_q <= 1'b1;
                  busy_q  <= 1'b1;
                  cnt_q   <= cnt_q + 1'b1;
               end
            end
            START: state_q <= BUSY;
            BUSY: begin
               if (i_done) begin
                  state_q  <= IDLE;
                  busy_q   <= 1'b0;
                  rd_ptr_q <= ~rd_ptr_q;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_start     = start_q;
   assign o_busy      = busy_q;
   assign o_data      = data_q;
   assign o_frame_cnt = cnt_q;
endmodule

// File: tb/tb_llr_frame_packer.sv
// Scoreboard bench for llr_frame_packer: a frame-level model predicts handshake, start timing and packed frames.
`timescale 1ns/1ps
module tb_llr_frame_packer;
   localparam int SW = 7;
   localparam int NS = 12;
   localparam int DW = SW * NS;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_valid = 1'b0;
   logic          i_done = 1'b0;
   logic [SW-1:0] i_sample = '0;
   logic          o_ready, o_start, o_busy;
   logic [DW-1:0] o_data;
   logic [CW-1:0] o_frame_cnt;

   always #5 clk = ~clk;

   llr_frame_packer #(.SAMPLE_W(SW), .SAMPLES(NS), .CNT_W(CW)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_sample(i_sample), .o_start(o_start), .o_data(o_data), .i_done(i_done),
      .o_frame_cnt(o_frame_cnt), .o_busy(o_busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: frames held (filled, not yet released), decoder phase, pending start countdown.
   logic [DW-1:0] sb[$];
   logic [DW-1:0] cur;
   int held = 0, idx = 0, pend = 0, dstate = 0;  // dstate: 0 idle, 1 start, 2 busy

   function automatic logic [SW-1:0] cond(input logic [SW-1:0] s);
`ifdef LLR_SAT_EN
      return (s == 7'h40) ? 7'h41 : s;
`else
      return s;
`endif
   endfunction

   task automatic step(input logic v, input logic [SW-1:0] s, input logic d, output logic acc);
      logic rel, fill, exp_start;
      @(negedge clk);
      if (dstate == 1) dstate = 2;
      exp_start = 1'b0;
      if (pend == 1) begin
         exp_start = 1'b1;
         dstate = 1;
         pend = 0;
      end else if (pend == 2) begin
         pend = 1;
      end
      check("start_timing", DW'(o_start), DW'(exp_start));
      check("ready", DW'(o_ready), DW'(held != 2));
      check("busy", DW'(o_busy), DW'(dstate != 0));
      i_valid = v;
      i_sample = s;
      i_done = d;
      acc = v && (held != 2);
      rel = d && (dstate == 2);
      fill = 1'b0;
      if (rel) begin
         held--;
         dstate = 0;
      end
      if (acc) begin
         cur[idx*SW +: SW] = cond(s);
         if (idx == NS - 1) begin
            sb.push_back(cur);
            held++;
            idx = 0;
            fill = 1'b1;
         end else begin
            idx++;
         end
      end
      if (rel && held >= 1) pend = 2;
      else if (fill && dstate == 0 && pend == 0) pend = 2;
   endtask

   task automatic send(input logic [SW-1:0] s, input logic d);
      logic acc;
      int n;
      n = 0;
      do begin
         step(1'b1, s, d, acc);
         n++;
      end while (!acc && n < 200);
      if (!acc) check("send_timeout", DW'(0), DW'(1));
   endtask

   task automatic idle(input int n, input logic d);
      logic acc;
      for (int i = 0; i < n; i++) step(1'b0, '0, d, acc);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      i_valid = 1'b0;
      i_done = 1'b0;
      #1;
      check("rst_start", DW'(o_start), DW'(0));
      check("rst_busy", DW'(o_busy), DW'(0));
      check("rst_data", o_data, DW'(0));
      check("rst_cnt", DW'(o_frame_cnt), DW'(0));
      repeat (2) @(negedge clk);
      sb.delete();
      held = 0; idx = 0; pend = 0; dstate = 0; cur = '0;
      rst_n = 1'b1;
   endtask

   // Monitor: every start pulse pops one expected frame; data must then hold while busy.
   logic [CW-1:0] exp_cnt = '0;
   logic [DW-1:0] hold_data = '0;
   logic          have_hold = 1'b0;
   int            frames_seen = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_cnt = '0;
         have_hold = 1'b0;
      end else if (o_start) begin
         exp_cnt = exp_cnt + 1'b1;
         frames_seen++;
         if (sb.size() == 0) begin
            check("unexpected_frame", DW'(1), DW'(0));
         end else begin
            hold_data = sb.pop_front();
            have_hold = 1'b1;
            check("frame_data", o_data, hold_data);
         end
         check("frame_cnt", DW'(o_frame_cnt), DW'(exp_cnt));
         $display("frame %0d cnt=%0d data=%h", frames_seen, o_frame_cnt, o_data);
      end else if (o_busy && have_hold) begin
         check("data_stable", o_data, hold_data);
      end else if (!o_busy) begin
         have_hold = 1'b0;
      end
   end

   initial begin
      logic acc, pv, v, d;
      logic [SW-1:0] ps, s;
      int n;
      cur = '0;
      do_reset();
      check("reset_ready", DW'(o_ready), DW'(1));

      // First frame 0..11 continuously, decoder never done.
      for (int k = 0; k < NS; k++) send(SW'(k), 1'b0);
      idle(4, 1'b0);

      // Second frame fills, third stalls with valid held high.
      for (int k = 12; k < 24; k++) send(SW'(k), 1'b0);
      for (int i = 0; i < 6; i++) step(1'b1, SW'(24), 1'b0, acc);
      step(1'b1, SW'(24), 1'b1, acc);
      for (int k = 24; k < 36; k++) send(SW'(k), 1'b0);
      idle(4, 1'b0);
      idle(1, 1'b1);
      idle(5, 1'b0);

      // Release coincides with the last sample of the following frame.
      for (int k = 0; k < NS - 1; k++) send(SW'($urandom), 1'b0);
      send(SW'($urandom), 1'b1);
      idle(5, 1'b0);
      idle(1, 1'b1);
      idle(4, 1'b0);
      idle(1, 1'b1);
      idle(4, 1'b0);

      // Done while idle has no effect.
      idle(2, 1'b1);
      idle(3, 1'b0);

      // Reset mid-frame, then a fresh frame starting with the most negative code.
      for (int k = 0; k < 5; k++) send(SW'(k + 100), 1'b0);
      do_reset();
      send(7'h40, 1'b0);
      for (int k = 1; k < NS; k++) send(SW'($urandom), 1'b0);
      idle(4, 1'b0);
      check("sat_lsb", DW'(o_data[SW-1:0]), DW'(cond(7'h40)));
      idle(1, 1'b1);
      idle(3, 1'b0);

      // Randomized traffic; upstream holds a refused sample.
      pv = 1'b0;
      ps = '0;
      for (int i = 0; i < 2500; i++) begin
         if (pv) begin
            v = 1'b1;
            s = ps;
         end else begin
            v = ($urandom_range(0, 9) < 7);
            s = ($urandom_range(0, 9) == 0) ? 7'h40 : SW'($urandom);
         end
         d = ($urandom_range(0, 3) == 0);
         step(v, s, d, acc);
         pv = v && !acc;
         ps = s;
      end

      n = 0;
      while ((held > 0 || dstate != 0 || pend != 0) && n < 300) begin
         idle(1, 1'b1);
         n++;
      end
      idle(3, 1'b0);
      check("drain_done", DW'(held == 0 && dstate == 0 && pend == 0), DW'(1));
      check("scoreboard_empty", DW'(sb.size()), DW'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
